// File: rtl/lcv_mul_acc_arbiter_if.sv
// Requester and response bundle for the shared multiply-accumulate arbiter.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
interface lcv_mul_acc_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [33*NUM_REQ-1:0] req_c;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_WIDTH-1:0]   rsp_id;
    logic [32:0]           rsp_data;

    modport master (
        output req_valid, req_a, req_b, req_c, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/lcv_mul_acc_arbiter.sv
// Round-robin sharing of one signed 16x16+33 multiply-accumulate stage among NUM_REQ requesters,
// with a credit-checked in-order response FIFO.
module lcv_mul_acc_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int RSP_DEPTH = 4,
    parameter int ID_WIDTH  = 4
) (
    input logic                    clk,
    input logic                    rst,
    lcv_mul_acc_arbiter_if.slave   bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int FA_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int CW1   = CNT_W + 1;

    logic [PTR_W-1:0]    prio_ptr;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W:0]      scan_sum;
    logic                grant_found;
    logic                issue_ok;
    logic                handshake;
    logic [NUM_REQ-1:0]  ready_vec;

    logic signed [15:0]  a_sel;
    logic signed [15:0]  b_sel;
    logic [32:0]         c_sel;
    logic signed [31:0]  prod;
    logic [32:0]         result;

    logic                s1_vld;
    logic [ID_WIDTH-1:0] s1_id;
    logic [32:0]         s1_data;

    logic [32:0]         mem_data [RSP_DEPTH];
    logic [ID_WIDTH-1:0] mem_id   [RSP_DEPTH];
    logic [FA_W-1:0]     wr_ptr;
    logic [FA_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_push;
    logic                fifo_pop;
    logic                rsp_valid_int;

    // Credit counts the s1 entry as already occupying a slot; a same-cycle pop does not free one.
    assign issue_ok = ({1'b0, fifo_count} + CW1'(s1_vld)) < CW1'(RSP_DEPTH);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            scan_sum = {1'b0, prio_ptr} + (PTR_W+1)'(off);
            if (scan_sum >= (PTR_W+1)'(NUM_REQ))
                scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
            if (!grant_found && bus.req_valid[scan_sum[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sum[PTR_W-1:0];
            end
        end
    end

    assign handshake     = grant_found && issue_ok && rst;
    assign ready_vec     = handshake ? (NUM_REQ'(1) << grant_idx) : '0;
    assign bus.req_ready = ready_vec;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        c_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                a_sel = bus.req_a[16*i +: 16];
                b_sel = bus.req_b[16*i +: 16];
                c_sel = bus.req_c[33*i +: 33];
            end
        end
    end

    // Full 32-bit signed product, sign-extended, then a wrapping 33-bit add.
    assign prod   = a_sel * b_sel;
    assign result = {prod[31], prod} + c_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_ptr <= '0;
            s1_vld   <= 1'b0;
            s1_id    <= '0;
            s1_data  <= '0;
        end else begin
            s1_vld <= handshake;
            if (handshake) begin
                s1_id    <= ID_WIDTH'(grant_idx);
                s1_data  <= result;
                prio_ptr <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
            end
        end
    end

    assign rsp_valid_int = (fifo_count != '0);
    assign fifo_push     = s1_vld;
    assign fifo_pop      = rsp_valid_int && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem_data[wr_ptr] <= s1_data;
            mem_id[wr_ptr]   <= s1_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push)
                wr_ptr <= (wr_ptr == FA_W'(RSP_DEPTH-1)) ? '0 : wr_ptr + FA_W'(1);
            if (fifo_pop)
                rd_ptr <= (rd_ptr == FA_W'(RSP_DEPTH-1)) ? '0 : rd_ptr + FA_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
    assign bus.rsp_valid = rsp_valid_int;
    assign bus.rsp_id    = rsp_valid_int ? mem_id[rd_ptr]   : '0;
    assign bus.rsp_data  = rsp_valid_int ? mem_data[rd_ptr] : '0;
endmodule

// File: tb/tb_lcv_mul_acc_arbiter.sv
// Bench for lcv_mul_acc_arbiter: directed steps plus random traffic, checked every cycle
// against a queue-based model of grants, credits and response order.
module tb_lcv_mul_acc_arbiter;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int IDW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lcv_mul_acc_arbiter_if #(.NUM_REQ(N), .ID_WIDTH(IDW)) bus ();

    lcv_mul_acc_arbiter #(.NUM_REQ(N), .RSP_DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mptr = 0;
    int dut_grants = 0;
    int dut_rsps = 0;

    logic signed [15:0] a_v [N];
    logic signed [15:0] b_v [N];
    logic signed [32:0] c_v [N];
    logic [N-1:0]       valid_v;
    logic               rdy_v;

    logic [36:0] exp_q [$];
    int          due_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] mac_ref(input logic signed [15:0] a, input logic signed [15:0] b,
                                            input logic signed [32:0] c);
        longint p;
        longint s;
        p = longint'(a) * longint'(b);
        s = p + longint'(c);
        return s[32:0];
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_a[16*i +: 16] = a_v[i];
            bus.req_b[16*i +: 16] = b_v[i];
            bus.req_c[33*i +: 33] = c_v[i];
        end
        bus.req_valid = valid_v;
        bus.rsp_ready = rdy_v;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            a_v[i] = 16'($urandom);
            b_v[i] = 16'($urandom);
            c_v[i] = {1'($urandom), 32'($urandom)};
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        due_q.delete();
        mptr = 0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        logic [N-1:0] exp_ready;
        logic         exp_rv;
        int           g;
        @(negedge clk);
        exp_ready = '0;
        g = -1;
        if (exp_q.size() < DEPTH) begin
            for (int off = 0; off < N; off++) begin
                int i;
                i = (mptr + off) % N;
                if (g < 0 && valid_v[i]) g = i;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        exp_rv = (exp_q.size() > 0) && (cyc >= due_q[0]);
        check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            check("rsp_id", 64'(bus.rsp_id), 64'(exp_q[0][36:33]));
            check("rsp_data", 64'(bus.rsp_data), 64'(exp_q[0][32:0]));
        end
        dut_grants += $countones(bus.req_ready);
        if (bus.rsp_valid && bus.rsp_ready) dut_rsps++;
        if (exp_rv && rdy_v) begin
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
        if (g >= 0) begin
            exp_q.push_back({4'(g), mac_ref(a_v[g], b_v[g], c_v[g])});
            due_q.push_back(cyc + 2);
            mptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g0;
        int r0;
        int tries;

        // Reset with random inputs applied
        rand_ops();
        valid_v = N'($urandom);
        rdy_v   = 1'($urandom);
        apply();
        repeat (3) @(posedge clk);
        #2;
        check("reset_req_ready", 64'(bus.req_ready), 64'(0));
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("reset_rsp_id", 64'(bus.rsp_id), 64'(0));
        check("reset_rsp_data", 64'(bus.rsp_data), 64'(0));

        @(negedge clk);
        valid_v = '0;
        apply();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // First operation: 3 * -5 + 7 = -8
        valid_v = 4'b0001;
        a_v[0] = 16'sd3;
        b_v[0] = -16'sd5;
        c_v[0] = 33'sd7;
        rdy_v = 1'b1;
        apply();
        #1;
        check("basic_grant", 64'(bus.req_ready), 64'(4'b0001));
        step();
        valid_v = '0;
        apply();
        step();
        check("basic_valid", 64'(bus.rsp_valid), 64'(1));
        check("basic_id", 64'(bus.rsp_id), 64'(0));
        check("basic_data", 64'(bus.rsp_data), 64'(33'h1_FFFF_FFF8));
        step();

        // Round-robin with all requesters valid
        valid_v = '1;
        rdy_v = 1'b1;
        repeat (12) begin
            rand_ops();
            apply();
            step();
        end

        // Fairness between requesters 0 and 2, then requester 1 joins
        valid_v = 4'b0101;
        repeat (6) begin
            rand_ops();
            apply();
            step();
        end
        tries = 0;
        while (mptr != 1 && tries < 8) begin
            step();
            tries++;
        end
        valid_v = 4'b0111;
        apply();
        #1;
        check("fair_raise", 64'(bus.req_ready), 64'(4'b0010));
        step();

        // Backpressure
        valid_v = '0;
        rdy_v = 1'b1;
        apply();
        repeat (6) step();
        rdy_v = 1'b0;
        valid_v = '1;
        rand_ops();
        apply();
        g0 = dut_grants;
        repeat (8) step();
        check("bp_grants", 64'(dut_grants - g0), 64'(4));
        #1;
        check("bp_idle", 64'(bus.req_ready), 64'(0));
        rdy_v = 1'b1;
        apply();
        step();
        rdy_v = 1'b0;
        apply();
        g0 = dut_grants;
        repeat (4) step();
        check("bp_regrant", 64'(dut_grants - g0), 64'(1));
        valid_v = '0;
        rdy_v = 1'b1;
        apply();
        repeat (8) step();

        // Arithmetic corners
        valid_v = 4'b0001;
        a_v[0] = 16'sh8000;
        b_v[0] = 16'sh8000;
        c_v[0] = 33'h0_FFFF_FFFF;
        apply();
        step();
        valid_v = '0;
        apply();
        step();
        check("arith_max", 64'(bus.rsp_data), 64'(33'h1_3FFF_FFFF));
        step();
        valid_v = 4'b0001;
        a_v[0] = 16'sd0;
        b_v[0] = 16'sd0;
        c_v[0] = 33'h1_FFFF_FFFF;
        apply();
        step();
        valid_v = '0;
        apply();
        step();
        check("arith_neg1", 64'(bus.rsp_data), 64'(33'h1_FFFF_FFFF));
        step();

        // Random traffic
        repeat (300) begin
            valid_v = N'($urandom);
            rdy_v = ($urandom_range(0, 3) != 0);
            rand_ops();
            apply();
            step();
        end
        valid_v = '0;
        rdy_v = 1'b1;
        apply();
        repeat (8) step();

        // Reset while the FIFO holds 3 entries and s1 is loaded
        rdy_v = 1'b0;
        valid_v = '1;
        rand_ops();
        apply();
        g0 = dut_grants;
        tries = 0;
        while ((dut_grants - g0) < 4 && tries < 10) begin
            step();
            tries++;
        end
        check("mid_pre_valid", 64'(bus.rsp_valid), 64'(1));
        #3;
        rst = 1'b0;
        #1;
        check("mid_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("mid_req_ready", 64'(bus.req_ready), 64'(0));
        model_reset();
        valid_v = '0;
        rdy_v = 1'b1;
        apply();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        valid_v = 4'b0100;
        rand_ops();
        apply();
        r0 = dut_rsps;
        step();
        valid_v = '0;
        apply();
        repeat (6) step();
        check("mid_rsp_count", 64'(dut_rsps - r0), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
